debounce_sync: RTL and testbench

//   Conditions a raw asynchronous 1-bit input (button, external strobe) into a clean,
//   clk-synchronous, glitch-free level. It is the stage directly upstream of

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_sync_chain.sv | 29 ++
 rtl/debounce_sync.sv | 116 +++++++++++
 tb/tb_debounce_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debounce/synchronizer block.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CNT_HI    = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CNT_LO    = 2'd3
  } state_t;

  // Counter width able to hold 0..n.
  function automatic int unsigned cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Plain multi-flop synchronizer for a single asynchronous bit; q is the last flop.
module sync_chain #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous input and only accepts a level change once it has
// been seen for DEBOUNCE_CYCLES consecutive synced samples.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_out,
  output logic busy
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam state_t ResetState = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  logic            sync_q;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sig_out_q, sig_out_d;

  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RESET_LEVEL)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (sync_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ResetState;
      cnt_q     <= '0;
      sig_out_q <= RESET_LEVEL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_out_d = sig_out_q;
    case (state_q)
      ST_STABLE_LO: begin
        cnt_d = '0;
        if (sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = ST_STABLE_HI;
            sig_out_d = 1'b1;
          end else begin
            state_d = ST_CNT_HI;
            cnt_d   = CntOne;
          end
        end
      end
      ST_CNT_HI: begin
        if (!sync_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = ST_STABLE_HI;
          sig_out_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_STABLE_HI: begin
        cnt_d = '0;
        if (!sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = ST_STABLE_LO;
            sig_out_d = 1'b0;
          end else begin
            state_d = ST_CNT_LO;
            cnt_d   = CntOne;
          end
        end
      end
      ST_CNT_LO: begin
        if (sync_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = ST_STABLE_LO;
          sig_out_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      // Unreachable encodings fall back to the stable state matching the output.
      default: begin
        state_d = sig_out_q ? ST_STABLE_HI : ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO);
  end

  assign sig_out = sig_out_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench: main instance (2 stages, 4 cycles, reset low) plus a
// reset-high, single-cycle instance.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst;
  logic sig_in;
  logic sig_out;
  logic busy;

  logic rst_b;
  logic sig_in_b;
  logic sig_out_b;
  logic busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .busy    (busy)
  );

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1),
    .RESET_LEVEL     (1'b1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst_b),
    .sig_in  (sig_in_b),
    .sig_out (sig_out_b),
    .busy    (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      tick();
      n_vec++;
      if (sig_out !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d: sig_out=%b busy=%b want 0 0", i, sig_out, busy);
      end
    end
    sig_in = 1'b0;
    rst    = 1'b0;
    tick();
    n_vec++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: sig_out=%b busy=%b want 0 0", sig_out, busy);
    end
    repeat (4) tick();
  endtask

  task automatic test_rise_latency();
    bit [0:5] exp_sig  = 6'b000001;
    bit [0:5] exp_busy = 6'b001110;
    sig_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (sig_out !== exp_sig[i] || busy !== exp_busy[i]) begin
        n_err++;
        $display("FAIL rise_latency edge %0d: sig_out=%b busy=%b want %b %b",
                 i + 1, sig_out, busy, exp_sig[i], exp_busy[i]);
      end
    end
    sig_in = 1'b0;
    repeat (6) tick();
    n_vec++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL fall_settle: sig_out=%b busy=%b want 0 0", sig_out, busy);
    end
  endtask

  task automatic test_short_pulse();
    bit [0:7] exp_busy = 8'b00111000;
    bit [0:9] exp_sig4 = 10'b0000011110;
    bit [0:9] exp_bsy4 = 10'b0011101110;
    for (int i = 0; i < 8; i++) begin
      sig_in = (i < 3);
      tick();
      n_vec++;
      if (sig_out !== 1'b0 || busy !== exp_busy[i]) begin
        n_err++;
        $display("FAIL pulse3 edge %0d: sig_out=%b busy=%b want 0 %b",
                 i + 1, sig_out, busy, exp_busy[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      sig_in = (i < 4);
      tick();
      n_vec++;
      if (sig_out !== exp_sig4[i] || busy !== exp_bsy4[i]) begin
        n_err++;
        $display("FAIL pulse4 edge %0d: sig_out=%b busy=%b want %b %b",
                 i + 1, sig_out, busy, exp_sig4[i], exp_bsy4[i]);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_bounce_restart();
    bit [0:7] pattern  = 8'b10111111;
    bit [0:7] exp_sig  = 8'b00000001;
    bit [0:7] exp_busy = 8'b00101110;
    for (int i = 0; i < 8; i++) begin
      sig_in = pattern[i];
      tick();
      n_vec++;
      if (sig_out !== exp_sig[i] || busy !== exp_busy[i]) begin
        n_err++;
        $display("FAIL bounce edge %0d: sig_out=%b busy=%b want %b %b",
                 i + 1, sig_out, busy, exp_sig[i], exp_busy[i]);
      end
    end
    sig_in = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_count();
    bit [0:5] exp_sig  = 6'b000001;
    bit [0:5] exp_busy = 6'b001110;
    sig_in = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midcount_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: sig_out=%b busy=%b want 0 0", sig_out, busy);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (sig_out !== exp_sig[i] || busy !== exp_busy[i]) begin
        n_err++;
        $display("FAIL post_reset edge %0d: sig_out=%b busy=%b want %b %b",
                 i + 1, sig_out, busy, exp_sig[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_reset_high_single();
    bit [0:4] exp_sig = 5'b11000;
    rst_b    = 1'b1;
    sig_in_b = 1'b1;
    #1;
    n_vec++;
    if (sig_out_b !== 1'b1 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL b_reset: sig_out=%b busy=%b want 1 0", sig_out_b, busy_b);
    end
    tick();
    rst_b = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (sig_out_b !== 1'b1 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL b_release: sig_out=%b busy=%b want 1 0", sig_out_b, busy_b);
    end
    sig_in_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (sig_out_b !== exp_sig[i] || busy_b !== 1'b0) begin
        n_err++;
        $display("FAIL b_fall edge %0d: sig_out=%b busy=%b want %b 0",
                 i + 1, sig_out_b, busy_b, exp_sig[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    sig_in   = 1'b0;
    rst_b    = 1'b1;
    sig_in_b = 1'b1;
    test_reset();
    test_rise_latency();
    test_short_pulse();
    test_bounce_restart();
    test_reset_mid_count();
    test_reset_high_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
